// File: rtl/bin2ascii_pkg.sv
// Shared definitions for the binary-to-ASCII serializer: state encoding,
// character constants and the decimal digit count for a given input width.
package bin2ascii_pkg;

  typedef logic [2:0] state_t;
  typedef logic [7:0] ascii_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CONV   = 3'd1;
  localparam state_t ST_LOCATE = 3'd2;
  localparam state_t ST_EMIT   = 3'd3;
  localparam state_t ST_SEPR   = 3'd4;

  localparam ascii_t ASCII_ZERO  = 8'h30;
  localparam ascii_t DEFAULT_SEP = 8'h20;

  // floor(width * log10(2)) + 1 decimal digits cover the largest unsigned value
  function automatic int digits(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin2ascii_serializer_if.sv
// Handshake bundle between the value producer, the serializer and the
// character sink.
interface bin2ascii_serializer_if #(
  parameter int WIDTH = 32
);
  import bin2ascii_pkg::*;

  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] IN_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  ascii_t           OUT_CHAR;
  logic             OUT_LAST;

  modport master (
    output IN_VALID, IN_DATA, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_CHAR, OUT_LAST
  );

  modport slave (
    input  IN_VALID, IN_DATA, OUT_READY,
    output IN_READY, OUT_VALID, OUT_CHAR, OUT_LAST
  );

endinterface

// File: rtl/bin2ascii_serializer_bcd.sv
// Iterative double-dabble converter: one input bit per cycle, MSB first,
// WIDTH cycles from start to a final BCD result that stays held afterwards.
module bin2bcd_iter
  import bin2ascii_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = digits(WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST_X,
  input  logic                  start,
  input  logic [WIDTH-1:0]      din,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]    bin_q;
  logic [DIGITS*4-1:0] bcd_q;
  logic [DIGITS*4-1:0] bcd_adj;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      else
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4];
    end
  end

  // done marks the cycle whose edge performs the final shift
  assign done = busy_q && (cnt_q == LAST_CNT);
  assign busy = busy_q;
  assign bcd  = bcd_q;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      bin_q  <= din;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bcd_q  <= (bcd_adj << 1) | {{(DIGITS*4-1){1'b0}}, bin_q[WIDTH-1]};
      bin_q  <= bin_q << 1;
      cnt_q  <= cnt_q + 1'b1;
      if (done)
        busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bin2ascii_serializer.sv
// Accepts one unsigned value at a time and streams its decimal ASCII digits,
// most significant first without leading zeros, closed by a separator.
module bin2ascii_serializer
  import bin2ascii_pkg::*;
#(
  parameter int   WIDTH = 32,
  parameter logic [7:0] SEP = DEFAULT_SEP
) (
  input  logic CLK,
  input  logic RST_X,
  bin2ascii_serializer_if.slave bus
);

  localparam int DIGITS = digits(WIDTH);
  localparam int IDX_W  = $clog2(DIGITS);

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    msd_idx;
  logic [DIGITS*4-1:0] bcd;
  logic [3:0]          cur_digit;
  logic                conv_busy;
  logic                conv_done;
  logic                in_ready;
  logic                in_fire;
  logic                out_fire;
  logic                out_valid;
  ascii_t              out_char;
  logic                out_last;

  assign in_ready = RST_X && (state_q == ST_IDLE) && !conv_busy;
  assign in_fire  = bus.IN_VALID && in_ready;
  assign out_fire = out_valid && bus.OUT_READY;

  bin2bcd_iter #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .CLK   (CLK),
    .RST_X (RST_X),
    .start (in_fire),
    .din   (bus.IN_DATA),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Highest nonzero digit wins; an all-zero value falls back to index 0
  always_comb begin
    msd_idx = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (bcd[i*4 +: 4] != 4'd0)
        msd_idx = IDX_W'(i);
    end
  end

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i))
        cur_digit = bcd[i*4 +: 4];
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE:   if (in_fire) state_q <= ST_CONV;
        ST_CONV:   if (conv_done) state_q <= ST_LOCATE;
        ST_LOCATE: begin
          idx_q   <= msd_idx;
          state_q <= ST_EMIT;
        end
        ST_EMIT: begin
          if (out_fire) begin
            if (idx_q == '0)
              state_q <= ST_SEPR;
            else
              idx_q <= idx_q - 1'b1;
          end
        end
        ST_SEPR:   if (out_fire) state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode state and held registers only, so stalls keep them stable
  always_comb begin
    out_valid = 1'b0;
    out_char  = 8'h00;
    out_last  = 1'b0;
    case (state_q)
      ST_EMIT: begin
        out_valid = 1'b1;
        out_char  = ASCII_ZERO + {4'b0000, cur_digit};
      end
      ST_SEPR: begin
        out_valid = 1'b1;
        out_char  = SEP;
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = out_valid;
  assign bus.OUT_CHAR  = out_char;
  assign bus.OUT_LAST  = out_last;

endmodule

// File: tb/tb_bin2ascii_serializer.sv
// Directed bench for bin2ascii_serializer: decimal text of single values,
// a Fibonacci stream, stalls, mid-number reset and back-to-back inputs.
module tb_bin2ascii_serializer;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic CLK;
  logic RST_X;
  int   errors;
  int   checks;
  logic [15:0] ready_pat;

  bin2ascii_serializer_if #(.WIDTH(W)) bus ();

  bin2ascii_serializer #(.WIDTH(W), .SEP(8'h20)) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .bus   (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Offers one value, then collects characters at falling edges until the
  // OUT_LAST transfer (or stop_after characters). Callers enter and leave
  // between a falling and the following rising edge.
  task automatic run_number(
    input  logic [W-1:0] value,
    input  bit           keep_valid,
    input  logic [W-1:0] next_value,
    input  int           ready_mode,
    input  int           stop_after,
    output string        text,
    output int           latency,
    output int           last_count,
    output int           unstable,
    output int           stalls,
    output int           accept_wait,
    output int           ready_high,
    output bit           timeout
  );
    int   n;
    int   chars;
    bit   ready;
    bit   pv, pr, pl;
    logic [7:0] pc;
    text = ""; latency = -1; last_count = 0; unstable = 0; stalls = 0;
    accept_wait = 0; ready_high = 0; timeout = 0; chars = 0;
    pv = 0; pr = 0; pl = 0; pc = 8'h00;
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = value;
    while (!bus.IN_READY && accept_wait < 100) begin
      @(negedge CLK);
      accept_wait++;
    end
    if (!bus.IN_READY) begin
      bus.IN_VALID = 1'b0;
      timeout = 1;
      return;
    end
    @(negedge CLK);
    if (keep_valid) bus.IN_DATA = next_value;
    else bus.IN_VALID = 1'b0;
    n = 0;
    while (n < 300) begin
      ready = (ready_mode == 0) ? 1'b1 : ready_pat[n % 16];
      bus.OUT_READY = ready;
      if (bus.IN_READY) ready_high++;
      if (bus.OUT_VALID) begin
        if (latency < 0) latency = n;
        if (pv && !pr && (bus.OUT_CHAR !== pc || bus.OUT_LAST !== pl)) unstable++;
        if (!ready) stalls++;
        else begin
          text = $sformatf("%s%c", text, bus.OUT_CHAR);
          chars++;
          if (bus.OUT_LAST) last_count++;
          if (bus.OUT_LAST || (stop_after > 0 && chars == stop_after)) return;
        end
      end else if (pv && !pr) begin
        unstable++;
      end
      pv = bus.OUT_VALID; pr = ready; pc = bus.OUT_CHAR; pl = bus.OUT_LAST;
      @(negedge CLK);
      n++;
    end
    timeout = 1;
  endtask

  task automatic test_reset();
    RST_X = 1'b0;
    bus.IN_VALID  = 1'b1;
    bus.IN_DATA   = '0;
    bus.OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (bus.IN_READY !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.IN_READY);
    end
    checks++;
    if (bus.OUT_VALID !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.OUT_VALID);
    end
    checks++;
    if (bus.OUT_CHAR !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_out_char: got %h expected 00", bus.OUT_CHAR);
    end
    checks++;
    if (bus.OUT_LAST !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_last: got %b expected 0", bus.OUT_LAST);
    end
    @(negedge CLK);
    RST_X = 1'b1;
    #1;
    checks++;
    if (bus.IN_READY !== 1'b1) begin
      errors++; $display("[TB] FAIL release_in_ready: got %b expected 1", bus.IN_READY);
    end
  endtask

  task automatic test_zero();
    string t; int lat, lc, us, st, aw, rh; bit to;
    run_number(32'd0, 0, 32'd0, 0, 0, t, lat, lc, us, st, aw, rh, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("[TB] FAIL zero_timeout: got 1 expected 0"); end
    checks++;
    if (t != "0 ") begin errors++; $display("[TB] FAIL zero_text: got \"%s\" expected \"0 \"", t); end
    checks++;
    if (lc !== 1) begin errors++; $display("[TB] FAIL zero_last: got %0d expected 1", lc); end
    checks++;
    if (aw !== 0) begin errors++; $display("[TB] FAIL zero_first_edge: got wait %0d expected 0", aw); end
    checks++;
    if (lat !== LAT) begin errors++; $display("[TB] FAIL zero_latency: got %0d expected %0d", lat, LAT); end
  endtask

  task automatic test_fibonacci();
    string t, all, exp_all, exp; int lat, lc, us, st, aw, rh; bit to;
    int a, b, nxt;
    a = 1; b = 1; all = ""; exp_all = "";
    for (int k = 0; k < 19; k++) begin
      exp = $sformatf("%0d ", a);
      exp_all = {exp_all, exp};
      run_number(W'(a), 0, '0, 0, 0, t, lat, lc, us, st, aw, rh, to);
      all = {all, t};
      checks++;
      if (t != exp || to) begin
        errors++; $display("[TB] FAIL fib_term%0d: got \"%s\" expected \"%s\"", k, t, exp);
      end
      nxt = a + b; a = b; b = nxt;
    end
    checks++;
    if (all != "1 1 2 3 5 8 13 21 34 55 89 144 233 377 610 987 1597 2584 4181 ") begin
      errors++; $display("[TB] FAIL fib_stream: got \"%s\" expected \"%s\"", all, exp_all);
    end
  endtask

  task automatic test_max();
    string t; int lat, lc, us, st, aw, rh; bit to;
    run_number(32'hFFFFFFFF, 0, '0, 0, 0, t, lat, lc, us, st, aw, rh, to);
    checks++;
    if (t != "4294967295 " || to) begin
      errors++; $display("[TB] FAIL max_text: got \"%s\" expected \"4294967295 \"", t);
    end
    checks++;
    if (t.len() !== 11) begin errors++; $display("[TB] FAIL max_len: got %0d expected 11", t.len()); end
    checks++;
    if (lat !== LAT) begin errors++; $display("[TB] FAIL max_latency: got %0d expected %0d", lat, LAT); end
  endtask

  task automatic test_stall();
    string t; int lat, lc, us, st, aw, rh; bit to;
    run_number(32'd6765, 0, '0, 1, 0, t, lat, lc, us, st, aw, rh, to);
    checks++;
    if (t != "6765 " || to) begin
      errors++; $display("[TB] FAIL stall_text: got \"%s\" expected \"6765 \"", t);
    end
    checks++;
    if (us !== 0) begin errors++; $display("[TB] FAIL stall_stable: got %0d unstable cycles expected 0", us); end
    checks++;
    if (st <= 0) begin errors++; $display("[TB] FAIL stall_exercised: got %0d stalls expected >0", st); end
    checks++;
    if (lat !== LAT) begin errors++; $display("[TB] FAIL stall_latency: got %0d expected %0d", lat, LAT); end
    bus.OUT_READY = 1'b1;
  endtask

  task automatic test_reset_abort();
    string t; int lat, lc, us, st, aw, rh; bit to;
    run_number(32'd1000, 0, '0, 0, 2, t, lat, lc, us, st, aw, rh, to);
    checks++;
    if (t != "10" || to) begin errors++; $display("[TB] FAIL abort_prefix: got \"%s\" expected \"10\"", t); end
    @(posedge CLK);
    #3;
    checks++;
    if (bus.OUT_VALID !== 1'b1 || bus.OUT_CHAR !== 8'h30) begin
      errors++; $display("[TB] FAIL abort_pre: got valid %b char %h expected 1 30", bus.OUT_VALID, bus.OUT_CHAR);
    end
    RST_X = 1'b0;
    #1;
    checks++;
    if (bus.OUT_VALID !== 1'b0 || bus.OUT_CHAR !== 8'h00 || bus.OUT_LAST !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_async: got valid %b char %h last %b expected 0 00 0",
                         bus.OUT_VALID, bus.OUT_CHAR, bus.OUT_LAST);
    end
    checks++;
    if (bus.IN_READY !== 1'b0) begin errors++; $display("[TB] FAIL abort_in_ready: got %b expected 0", bus.IN_READY); end
    repeat (2) @(negedge CLK);
    RST_X = 1'b1;
    run_number(32'd7, 0, '0, 0, 0, t, lat, lc, us, st, aw, rh, to);
    checks++;
    if (t != "7 " || to) begin errors++; $display("[TB] FAIL abort_after: got \"%s\" expected \"7 \"", t); end
  endtask

  task automatic test_back_to_back();
    string t1, t2; int lat, lc, us, st, aw1, aw2, rh1, rh2; bit to1, to2;
    run_number(32'd21, 1, 32'd34, 0, 0, t1, lat, lc, us, st, aw1, rh1, to1);
    run_number(32'd34, 0, '0, 0, 0, t2, lat, lc, us, st, aw2, rh2, to2);
    checks++;
    if ({t1, t2} != "21 34 " || to1 || to2) begin
      errors++; $display("[TB] FAIL b2b_text: got \"%s%s\" expected \"21 34 \"", t1, t2);
    end
    checks++;
    if (rh1 !== 0 || rh2 !== 0) begin
      errors++; $display("[TB] FAIL b2b_in_ready: got %0d/%0d ready cycles expected 0/0", rh1, rh2);
    end
    checks++;
    if (aw2 !== 1) begin errors++; $display("[TB] FAIL b2b_accept: got wait %0d expected 1", aw2); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    ready_pat = 16'b1011_0010_1101_0110;
    test_reset();
    test_zero();
    test_fibonacci();
    test_max();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin2ascii_serializer.md
BIN2ASCII_SERIALIZER -- requirements
Module: bin2ascii_serializer

Interface
REQ-001 The parameter WIDTH SHALL default to 32 and set the unsigned input value width; supported range is 4..64.
REQ-002 The parameter SEP SHALL default to 8'h20 and set the separator character appended after every number.
REQ-003 The port CLK SHALL be an input, 1 bit wide, and is the single clock; all state changes on its rising edge.
REQ-004 The port RST_X SHALL be an input, 1 bit wide, and is the reset, which is asynchronous and active-low.
REQ-005 The port IN_VALID SHALL be an input, 1 bit wide, and signals that upstream is offering IN_DATA.
REQ-006 The port IN_READY SHALL be an output, 1 bit wide, and signals that the block can accept a value.
REQ-007 The port IN_DATA SHALL be an input, WIDTH bits wide, and carries the unsigned binary value, e.g. a Fibonacci term from the generator.
REQ-008 The port OUT_VALID SHALL be an output, 1 bit wide, and signals that OUT_CHAR is valid.
REQ-009 The port OUT_READY SHALL be an input, 1 bit wide, and signals that the downstream character sink accepts OUT_CHAR.
REQ-010 The port OUT_CHAR SHALL be an output, 8 bits wide, and carries one ASCII character.
REQ-011 The port OUT_LAST SHALL be an output, 1 bit wide, and marks the separator character that closes a number.

Function
REQ-012 A transfer SHALL occur on a rising edge where VALID=1 and READY=1; there is no other transfer condition on either port.
REQ-013 DIGITS SHALL equal floor(WIDTH*30103/100000)+1, which gives 10 for WIDTH=32 and 20 for WIDTH=64.
REQ-014 The FSM SHALL have the states IDLE, CONV, LOCATE, EMIT and SEPR.
REQ-015 IN_READY SHALL be 1 only in IDLE with RST_X=1; there is no overlap between numbers.
REQ-016 In IDLE, an input transfer SHALL capture IN_DATA, clear the BCD accumulator and move the FSM to CONV.
REQ-017 CONV SHALL run for exactly WIDTH cycles of double-dabble (add 3 to every digit >=5, then shift left one bit, MSB first) and then move to LOCATE.
REQ-018 LOCATE SHALL take exactly one cycle, set the digit index to the most significant nonzero BCD digit (index 0 if the value is 0), and then move to EMIT.
REQ-019 In EMIT, OUT_VALID SHALL be 1 and OUT_CHAR SHALL equal 8'h30 + digit[index]; on an output transfer, index 0 moves the FSM to SEPR and any other index decrements.
REQ-020 In SEPR, OUT_VALID, OUT_CHAR=SEP and OUT_LAST SHALL all be driven; on an output transfer the FSM moves to IDLE.
REQ-021 Leading zeros SHALL never be emitted, and the value 0 SHALL emit exactly "0" followed by SEP.
REQ-022 Latency SHALL be fixed: for an input transfer at edge e, the first OUT_VALID is high after edge e+WIDTH+1, independent of OUT_READY.
REQ-023 While OUT_VALID=1 and OUT_READY=0, OUT_CHAR and OUT_LAST SHALL hold stable, and OUT_VALID SHALL not drop until the transfer occurs.
REQ-024 OUT_VALID, OUT_CHAR and OUT_LAST SHALL come from registers or state decode only, with no combinational path from OUT_READY or IN_VALID.
REQ-025 Outside EMIT and SEPR, OUT_VALID and OUT_LAST SHALL be 0 and OUT_CHAR SHALL be 8'h00.
REQ-026 The maximum input 2^WIDTH-1 SHALL produce DIGITS characters with no overflow of the BCD accumulator.

Reset
REQ-027 While RST_X=0, the FSM SHALL be in IDLE with IN_READY=0, OUT_VALID=0, OUT_CHAR=8'h00, OUT_LAST=0, and the BCD accumulator, digit index and cycle counter at 0.
REQ-028 Reset asserted mid-operation SHALL abort immediately, without waiting for a clock edge; a partially emitted number is never resumed.
REQ-029 The first input transfer SHALL be possible on the first rising edge after RST_X returns to 1.

Structure
REQ-030 A shared package bin2ascii_pkg SHALL hold the state encoding, ASCII_ZERO=8'h30, the default SEP, and the DIGITS(WIDTH) function.
REQ-031 The conversion SHALL live in one sub-module, bin2bcd_iter, with start/busy/done signals and a DIGITS*4-bit output; the top level holds the handshake FSM and the emitter.

Verification
REQ-032 Release reset, send IN_DATA=0 with OUT_READY=1 -> the bench sees '0' (8'h30) then 8'h20 with OUT_LAST=1, and no other characters.
REQ-033 Stream the first 19 Fibonacci terms 1,1,2,...,4181 with OUT_READY=1 -> the bench sees the exact string "1 1 2 3 5 8 13 ... 2584 4181 ".
REQ-034 Send 32'hFFFFFFFF -> the bench sees "4294967295 " (11 characters), with the first OUT_VALID after edge e+33.
REQ-035 Send 6765 with OUT_READY randomly toggled -> the bench sees '6','7','6','5',' ' with no drop or duplicate, and OUT_CHAR stable during stalls.
REQ-036 Send 1000, then assert RST_X=0 after "10" has been emitted -> outputs go to 0 asynchronously; after release, sending 7 gives "7 " only.
REQ-037 Hold IN_VALID=1 with data 21 then 34 -> IN_READY=0 from acceptance through the OUT_LAST transfer, and the bench sees "21 34 " in order.
